base4_digit_serializer: RTL

- Inverse of the block-level base-4 accumulator: accepts one 8-bit value, splits it into base-4 digits and streams them out one digit per accepted handshake.
- Each digit is presented zero-extended to a byte, matching the byte-per-digit input format of the base-4 converter.
- Sits upstream of that converter, or any digit consumer, in the conversion datapath.
- Signals completion with a one-cycle Ack pulse.

---
 rtl/base4_pkg.sv | 18 +
 rtl/base4_digit_shreg.sv | 55 +++++
 rtl/base4_digit_serializer.sv | 98 +++++++++
 3 files changed

// File: rtl/base4_pkg.sv
// Shared constants, state encoding and index type for the base-4 digit
// serializer. Optional build macro: BASE4_SER_MSB_FIRST_EN (MSB-first order).
package base4_pkg;

    localparam int DIGITS    = 4;
    localparam int BASE_LOG2 = 2;
    localparam int WIDTH     = 8;
    localparam int DW        = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [1:0] idx_t;

endpackage

// File: rtl/base4_digit_shreg.sv
// Loadable digit shift register. Exposes the digit to be sent next.
// Optional build macro: BASE4_SER_MSB_FIRST_EN selects left shift with the
// digit taken from the top of the register; otherwise it shifts right and the
// digit is taken from the bottom.
module base4_digit_shreg
    import base4_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 shift,
    input  logic [WIDTH-1:0]     din,
    output logic [BASE_LOG2-1:0] digit
);

    logic [WIDTH-1:0] shreg_reg;
    logic [WIDTH-1:0] shifted;

    // Each digit lane takes its neighbour's contents; the vacated end lane is zero.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lane
`ifdef BASE4_SER_MSB_FIRST_EN
            if (gi == 0) begin : g_end
                assign shifted[gi*BASE_LOG2 +: BASE_LOG2] = '0;
            end else begin : g_mid
                assign shifted[gi*BASE_LOG2 +: BASE_LOG2] = shreg_reg[(gi-1)*BASE_LOG2 +: BASE_LOG2];
            end
`else
            if (gi == DIGITS-1) begin : g_end
                assign shifted[gi*BASE_LOG2 +: BASE_LOG2] = '0;
            end else begin : g_mid
                assign shifted[gi*BASE_LOG2 +: BASE_LOG2] = shreg_reg[(gi+1)*BASE_LOG2 +: BASE_LOG2];
            end
`endif
        end
    endgenerate

`ifdef BASE4_SER_MSB_FIRST_EN
    assign digit = shreg_reg[WIDTH-1 -: BASE_LOG2];
`else
    assign digit = shreg_reg[BASE_LOG2-1:0];
`endif

    // Register update: load has priority over shift; reset clears the value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_reg <= '0;
        end else if (load) begin
            shreg_reg <= din;
        end else if (shift) begin
            shreg_reg <= shifted;
        end
    end

endmodule

// File: rtl/base4_digit_serializer.sv
// Splits an 8-bit value into base-4 digits and streams them one per
// Valid/Ready handshake, then pulses Ack for one cycle.
// Optional build macro: BASE4_SER_MSB_FIRST_EN emits the most significant
// digit first; Idx always reports the true digit weight.
module base4_digit_serializer
    import base4_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] X,
    input  logic             Ready,
    output logic [DW-1:0]    D,
    output logic             Valid,
    output logic [1:0]       Idx,
    output logic             Busy,
    output logic             Ack
);

`ifdef BASE4_SER_MSB_FIRST_EN
    localparam idx_t FIRST_IDX = idx_t'(DIGITS-1);
    localparam idx_t LAST_IDX  = idx_t'(0);
`else
    localparam idx_t FIRST_IDX = idx_t'(0);
    localparam idx_t LAST_IDX  = idx_t'(DIGITS-1);
`endif

    state_t state_reg, state_next;
    idx_t   idx_reg, idx_next;
    logic   load;
    logic   shift;
    logic [BASE_LOG2-1:0] digit;

    base4_digit_shreg u_shreg (
        .clk   (Clk),
        .rst_n (Rst_n),
        .load  (load),
        .shift (shift),
        .din   (X),
        .digit (digit)
    );

    // State and digit index registers.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // Next-state logic: capture on Start in IDLE, advance on each transfer.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        load       = 1'b0;
        shift      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (Start) begin
                    load       = 1'b1;
                    idx_next   = FIRST_IDX;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (Ready) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        shift = 1'b1;
`ifdef BASE4_SER_MSB_FIRST_EN
                        idx_next = idx_reg - idx_t'(1);
`else
                        idx_next = idx_reg + idx_t'(1);
`endif
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the state register.
    assign Valid = (state_reg == SEND);
    assign Busy  = (state_reg != IDLE);
    assign Ack   = (state_reg == DONE);
    assign Idx   = idx_reg;
    assign D     = Valid ? {{(DW-BASE_LOG2){1'b0}}, digit} : '0;

endmodule
